// File: rtl/hilo_ctrl_pkg.sv
// Shared mult/div type and HI/LO operation codes used by the EX-stage HI/LO controller.
package hilo_ctrl_pkg;

    localparam logic [2:0] MDTYPE_NONE  = 3'b000;
    localparam logic [2:0] MDTYPE_MULT  = 3'b100;
    localparam logic [2:0] MDTYPE_MULTU = 3'b101;
    localparam logic [2:0] MDTYPE_DIV   = 3'b110;
    localparam logic [2:0] MDTYPE_DIVU  = 3'b111;

    localparam logic [2:0] HILO_OP_NONE = 3'b000;
    localparam logic [2:0] HILO_OP_MFHI = 3'b001;
    localparam logic [2:0] HILO_OP_MFLO = 3'b010;
    localparam logic [2:0] HILO_OP_MTHI = 3'b011;
    localparam logic [2:0] HILO_OP_MTLO = 3'b100;

    // True for the four codes that touch HI/LO; unused codes act as no-ops.
    function automatic logic isHiLoOp(input logic [2:0] op);
        case (op)
            HILO_OP_MFHI, HILO_OP_MFLO, HILO_OP_MTHI, HILO_OP_MTLO: isHiLoOp = 1'b1;
            default:                                                 isHiLoOp = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO owner and mult/div issue controller sitting behind the iterative multdiv unit.
// Provides result capture, MF*/MT* service, the HI/LO interlock and a busy watchdog.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic        iCLK,
    input  logic        iReset,
    input  logic        iValid,
    input  logic        iKill,
    input  logic        iMemStall,
    input  logic [2:0]  iMDtype,
    input  logic [2:0]  iHiLoOp,
    input  logic [31:0] iRS,
    input  logic        iMDReady,
    input  logic [31:0] iMDHI,
    input  logic [31:0] iMDLO,
    output logic [2:0]  oMDtype,
    output logic        oMDHold,
    output logic [31:0] oResult,
    output logic        oStall,
    output logic        oError
);

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WD_ONE  = CW'(1);
    localparam logic [CW-1:0]  WD_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]  WD_TRIP = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         stateR, stateNextS;
    logic [31:0]    hiR, loR, hiNextS, loNextS;
    logic [CW-1:0]  wdCntR;
    logic           errorR;
    logic           actS, capS, mdReqS, hiloReqS, stallS, issueOkS, issueS, wdTickS;

    // Interlock, issue qualification and next-state selection.
    always_comb begin
        actS       = iValid & ~iKill;
        capS       = (stateR == BUSY) & iMDReady;
        mdReqS     = (iMDtype != MDTYPE_NONE);
        hiloReqS   = isHiLoOp(iHiLoOp);
        stallS     = actS & (stateR == BUSY) & ~iMDReady & (hiloReqS | mdReqS);
        issueOkS   = actS & ~stallS & ~iMemStall;
        issueS     = issueOkS & mdReqS;
        wdTickS    = (stateR == BUSY) & ~iMemStall;
        stateNextS = stateR;
        case (stateR)
            IDLE: begin
                if (issueS) stateNextS = BUSY;
                else        stateNextS = IDLE;
            end
            BUSY: begin
                if (issueS)     stateNextS = BUSY;
                else if (capS)  stateNextS = IDLE;
                else            stateNextS = BUSY;
            end
            default: stateNextS = IDLE;
        endcase
    end

    // HI/LO next values: an MT* write beats the captured multdiv result for its register.
    always_comb begin
        hiNextS = hiR;
        loNextS = loR;
        if (issueOkS && (iHiLoOp == HILO_OP_MTHI)) hiNextS = iRS;
        else if (capS)                             hiNextS = iMDHI;
        else                                       hiNextS = hiR;
        if (issueOkS && (iHiLoOp == HILO_OP_MTLO)) loNextS = iRS;
        else if (capS)                             loNextS = iMDLO;
        else                                       loNextS = loR;
    end

    // MF* read data, forwarding the multdiv result in the capture cycle.
    always_comb begin
        oResult = 32'h0000_0000;
        case (iHiLoOp)
            HILO_OP_MFHI: oResult = capS ? iMDHI : hiR;
            HILO_OP_MFLO: oResult = capS ? iMDLO : loR;
            default:      oResult = 32'h0000_0000;
        endcase
    end

    // Outputs toward multdiv and the pipeline.
    always_comb begin
        oMDtype = issueOkS ? iMDtype : MDTYPE_NONE;
        oMDHold = iMemStall;
        oStall  = stallS;
        oError  = errorR;
    end

    // State, HI/LO and watchdog registers.
    always_ff @(posedge iCLK) begin
        if (iReset) begin
            stateR <= IDLE;
            hiR    <= 32'h0000_0000;
            loR    <= 32'h0000_0000;
            wdCntR <= {CW{1'b0}};
            errorR <= 1'b0;
        end else begin
            stateR <= stateNextS;
            hiR    <= hiNextS;
            loR    <= loNextS;
            // A fresh issue restarts the count even when it replaces a finishing op.
            if (issueS)                          wdCntR <= {CW{1'b0}};
            else if (wdTickS && wdCntR != WD_MAX) wdCntR <= wdCntR + WD_ONE;
            else                                 wdCntR <= wdCntR;
            if (wdTickS && wdCntR == WD_TRIP)    errorR <= 1'b1;
            else                                 errorR <= errorR;
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl; the bench plays the role of multdiv.
module tb_hilo_ctrl;

    logic        iCLK;
    logic        iReset;
    logic        iValid;
    logic        iKill;
    logic        iMemStall;
    logic [2:0]  iMDtype;
    logic [2:0]  iHiLoOp;
    logic [31:0] iRS;
    logic        iMDReady;
    logic [31:0] iMDHI;
    logic [31:0] iMDLO;
    logic [2:0]  oMDtype;
    logic        oMDHold;
    logic [31:0] oResult;
    logic        oStall;
    logic        oError;

    int checks = 0;
    int errors = 0;

    hilo_ctrl #(.TIMEOUT(40)) dut (
        .iCLK     (iCLK),
        .iReset   (iReset),
        .iValid   (iValid),
        .iKill    (iKill),
        .iMemStall(iMemStall),
        .iMDtype  (iMDtype),
        .iHiLoOp  (iHiLoOp),
        .iRS      (iRS),
        .iMDReady (iMDReady),
        .iMDHI    (iMDHI),
        .iMDLO    (iMDLO),
        .oMDtype  (oMDtype),
        .oMDHold  (oMDHold),
        .oResult  (oResult),
        .oStall   (oStall),
        .oError   (oError)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        iReset = 1'b1; iValid = 1'b0; iKill = 1'b0; iMemStall = 1'b0;
        iMDtype = 3'b000; iHiLoOp = 3'b000; iRS = 32'h0;
        iMDReady = 1'b0; iMDHI = 32'h0; iMDLO = 32'h0;
        repeat (3) @(posedge iCLK);
        #1;
        iReset = 1'b0;
        #1;

        // 1: reset state
        chk("rst_stall",  {31'h0, oStall}, 32'h0);
        chk("rst_mdtype", {29'h0, oMDtype}, 32'h0);
        chk("rst_error",  {31'h0, oError}, 32'h0);
        chk("rst_result", oResult, 32'h0);
        iValid = 1'b1; iHiLoOp = 3'b001; #1;
        chk("rst_mfhi", oResult, 32'h0);
        iHiLoOp = 3'b010; #1;
        chk("rst_mflo", oResult, 32'h0);
        chk("rst_mf_stall", {31'h0, oStall}, 32'h0);

        // 2: MULT -2*3 with a dependent MFLO
        tick(); iHiLoOp = 3'b000; iMDtype = 3'b100; #1;
        chk("mult_issue", {29'h0, oMDtype}, 32'h4);
        chk("mult_issue_stall", {31'h0, oStall}, 32'h0);
        for (int c = 1; c <= 32; c++) begin
            tick(); iMDtype = 3'b000; iHiLoOp = 3'b010; iMDReady = 1'b0; #1;
            chk("mult_mflo_stall", {31'h0, oStall}, 32'h1);
        end
        tick(); iMDReady = 1'b1; iMDHI = 32'hFFFF_FFFF; iMDLO = 32'hFFFF_FFFA; #1;
        chk("mult_cap_stall", {31'h0, oStall}, 32'h0);
        chk("mult_cap_fwd_lo", oResult, 32'hFFFF_FFFA);
        tick(); iMDReady = 1'b0; iMDHI = 32'h0; iMDLO = 32'h0; iHiLoOp = 3'b001; #1;
        chk("mult_mfhi", oResult, 32'hFFFF_FFFF);
        chk("mult_mfhi_stall", {31'h0, oStall}, 32'h0);

        // 3: DIVU 7/2 then back-to-back MULTU issued in the capture cycle
        tick(); iHiLoOp = 3'b000; iMDtype = 3'b111; #1;
        chk("divu_issue", {29'h0, oMDtype}, 32'h7);
        for (int c = 1; c <= 32; c++) begin
            tick(); iMDtype = 3'b101; iMDReady = 1'b0; #1;
            chk("multu_wait_stall", {31'h0, oStall}, 32'h1);
            chk("multu_wait_mdtype", {29'h0, oMDtype}, 32'h0);
        end
        tick(); iMDReady = 1'b1; iMDHI = 32'h1; iMDLO = 32'h3; #1;
        chk("multu_cap_stall", {31'h0, oStall}, 32'h0);
        chk("multu_cap_issue", {29'h0, oMDtype}, 32'h5);
        tick(); iMDtype = 3'b000; iHiLoOp = 3'b010; iMDReady = 1'b0; iMDHI = 32'h0; iMDLO = 32'h0; #1;
        chk("multu_busy_stall", {31'h0, oStall}, 32'h1);
        for (int c = 2; c <= 32; c++) tick();
        tick(); iMDReady = 1'b1; iMDHI = 32'h1; iMDLO = 32'h0; #1;
        chk("multu_cap_fwd_lo", oResult, 32'h0);
        chk("multu_cap_stall2", {31'h0, oStall}, 32'h0);
        tick(); iMDReady = 1'b0; iMDHI = 32'h0; iHiLoOp = 3'b001; #1;
        chk("multu_hi", oResult, 32'h1);
        iHiLoOp = 3'b010; #1;
        chk("multu_lo", oResult, 32'h0);

        // 4: MTHI when idle; MTLO held across BUSY and merged in the capture cycle
        tick(); iHiLoOp = 3'b011; iRS = 32'h1234_5678; #1;
        chk("mthi_stall", {31'h0, oStall}, 32'h0);
        chk("mthi_result", oResult, 32'h0);
        tick(); iHiLoOp = 3'b001; iRS = 32'h0; #1;
        chk("mthi_readback", oResult, 32'h1234_5678);
        tick(); iHiLoOp = 3'b000; iMDtype = 3'b110; #1;
        chk("div_issue", {29'h0, oMDtype}, 32'h6);
        for (int c = 1; c <= 4; c++) begin
            tick(); iMDtype = 3'b000; iHiLoOp = 3'b100; iRS = 32'hAAAA_5555; iMDReady = 1'b0; #1;
            chk("mtlo_busy_stall", {31'h0, oStall}, 32'h1);
        end
        tick(); iMDReady = 1'b1; iMDHI = 32'h5; iMDLO = 32'h7; #1;
        chk("mtlo_cap_stall", {31'h0, oStall}, 32'h0);
        tick(); iMDReady = 1'b0; iMDHI = 32'h0; iMDLO = 32'h0; iHiLoOp = 3'b010; iRS = 32'h0; #1;
        chk("mtlo_wins_lo", oResult, 32'hAAAA_5555);
        iHiLoOp = 3'b001; #1;
        chk("div_rem_hi", oResult, 32'h5);

        // 5: killed MULT does not issue; memory stall blocks issue and drives hold
        tick(); iHiLoOp = 3'b000; iMDtype = 3'b100; iKill = 1'b1; #1;
        chk("kill_mdtype", {29'h0, oMDtype}, 32'h0);
        tick(); iKill = 1'b0; iMDtype = 3'b000; iHiLoOp = 3'b010; #1;
        chk("kill_no_stall", {31'h0, oStall}, 32'h0);
        chk("kill_lo_kept", oResult, 32'hAAAA_5555);
        tick(); iHiLoOp = 3'b000; iMDtype = 3'b100; iMemStall = 1'b1; #1;
        chk("memstall_mdtype", {29'h0, oMDtype}, 32'h0);
        chk("memstall_hold", {31'h0, oMDHold}, 32'h1);
        tick(); iMemStall = 1'b0; iMDtype = 3'b000; iHiLoOp = 3'b010; #1;
        chk("memstall_no_busy", {31'h0, oStall}, 32'h0);
        chk("memstall_hold_off", {31'h0, oMDHold}, 32'h0);

        // 6: reset during BUSY, then the watchdog
        tick(); iHiLoOp = 3'b000; iMDtype = 3'b100; #1;
        chk("rst_busy_issue", {29'h0, oMDtype}, 32'h4);
        for (int c = 1; c <= 9; c++) begin
            tick(); iMDtype = 3'b000; iHiLoOp = 3'b010; #1;
            chk("rst_busy_stall", {31'h0, oStall}, 32'h1);
        end
        tick(); iReset = 1'b1; iHiLoOp = 3'b000;
        tick(); iReset = 1'b0; iHiLoOp = 3'b010; #1;
        chk("rst_mid_stall", {31'h0, oStall}, 32'h0);
        chk("rst_mid_lo", oResult, 32'h0);
        iHiLoOp = 3'b001; #1;
        chk("rst_mid_hi", oResult, 32'h0);
        chk("rst_mid_error", {31'h0, oError}, 32'h0);
        tick(); iHiLoOp = 3'b000; iMDtype = 3'b100; #1;
        chk("wd_issue", {29'h0, oMDtype}, 32'h4);
        for (int c = 1; c <= 40; c++) begin
            tick(); iMDtype = 3'b000; iValid = 1'b0; #1;
            chk("wd_quiet", {31'h0, oError}, 32'h0);
        end
        tick(); #1;
        chk("wd_trip", {31'h0, oError}, 32'h1);
        tick(); iMDReady = 1'b1; #1;
        chk("wd_sticky_cap", {31'h0, oError}, 32'h1);
        tick(); iMDReady = 1'b0; iValid = 1'b1; iHiLoOp = 3'b010; #1;
        chk("wd_sticky_idle", {31'h0, oError}, 32'h1);
        chk("wd_idle_stall", {31'h0, oStall}, 32'h0);
        tick(); tick(); #1;
        chk("wd_sticky_late", {31'h0, oError}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
